// File: rtl/ysyx_22041412_decode_stage.sv
// Decode stage: one-entry pipeline register between fetch and execute.
// Splits a raw RV32/RV64 instruction into fields, builds the sign-extended
// immediate, picks operand sources and flags illegal encodings. Handshake
// is valid/ready on both sides; illegal instructions flow through unchanged.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_instr/in_pc the instruction
//   flush                drop the held bundle and any incoming instruction
//   out_valid/out_ready  downstream handshake
//   out_pc, opcode, func3, func7, rs1, rs2, rd, imme, v1type, v2type,
//   mul_en, rd_wen, illegal   registered decoded bundle
module ysyx_22041412_decode_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RVM_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic            func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imme,
  output logic            v1type,
  output logic            v2type,
  output logic            mul_en,
  output logic            rd_wen,
  output logic            illegal
);

  typedef enum logic [2:0] {FmtNone, FmtI, FmtU, FmtJ, FmtB, FmtS, FmtR} fmt_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam bit IsRv64 = (XLEN == 64);
  localparam bit HasM   = (RVM_EN != 0);

  logic [6:0]  op;
  fmt_e        fmt;
  logic        illegal_d;
  logic [63:0] imm64;
  logic        v1type_d;
  logic        v2type_d;
  logic        mul_en_d;
  logic        rd_wen_d;
  logic        transfer;

  assign op = in_instr[6:0];

  // Reset also blocks acceptance so nothing slips in during the reset cycle.
  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign transfer = in_valid && in_ready;

  always_comb begin
    fmt = FmtNone;
    case (op)
      OpJalr, OpLoad, OpOpImm, OpSystem: fmt = FmtI;
      OpImm32:                           fmt = IsRv64 ? FmtI : FmtNone;
      OpLui, OpAuipc:                    fmt = FmtU;
      OpJal:                             fmt = FmtJ;
      OpBranch:                          fmt = FmtB;
      OpStore:                           fmt = FmtS;
      OpOp:                              fmt = FmtR;
      OpOp32:                            fmt = IsRv64 ? FmtR : FmtNone;
      default:                           fmt = FmtNone;
    endcase
  end

  always_comb begin
    illegal_d = (in_instr[1:0] != 2'b11) || (fmt == FmtNone) ||
                ((fmt == FmtR) && in_instr[25] && !HasM);

    imm64    = '0;
    v1type_d = 1'b0;
    v2type_d = 1'b0;
    mul_en_d = 1'b0;
    rd_wen_d = 1'b0;

    if (!illegal_d) begin
      case (fmt)
        FmtI: imm64 = {{52{in_instr[31]}}, in_instr[31:20]};
        FmtU: imm64 = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
        FmtJ: imm64 = {{43{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
        FmtB: imm64 = {{51{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
        FmtS: imm64 = {{52{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        default: imm64 = '0;
      endcase

      // Only jal and auipc take the PC as first operand.
      v1type_d = (op == OpJal) || (op == OpAuipc);
      v2type_d = (fmt == FmtI) || (fmt == FmtU) || (fmt == FmtS) || (fmt == FmtJ);
      mul_en_d = (fmt == FmtR) && in_instr[25] && HasM;
      rd_wen_d = ((fmt == FmtI) || (fmt == FmtU) || (fmt == FmtJ) || (fmt == FmtR)) &&
                 (in_instr[11:7] != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      opcode    <= '0;
      func3     <= '0;
      func7     <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imme      <= '0;
      v1type    <= 1'b0;
      v2type    <= 1'b0;
      mul_en    <= 1'b0;
      rd_wen    <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      // Bundle contents are left as-is; only validity is dropped.
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      opcode    <= op;
      func3     <= in_instr[14:12];
      func7     <= in_instr[30];
      rs1       <= in_instr[19:15];
      rs2       <= in_instr[24:20];
      rd        <= in_instr[11:7];
      imme      <= imm64[XLEN-1:0];
      v1type    <= v1type_d;
      v2type    <= v2type_d;
      mul_en    <= mul_en_d;
      rd_wen    <= rd_wen_d;
      illegal   <= illegal_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_decode_stage.sv
module tb_ysyx_22041412_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Main DUT: XLEN=64, RVM_EN=1.
  logic        a_in_ready, a_out_valid, a_func7, a_v1type, a_v2type, a_mul_en, a_rd_wen,
               a_illegal;
  logic [63:0] a_out_pc, a_imme;
  logic [6:0]  a_opcode;
  logic [2:0]  a_func3;
  logic [4:0]  a_rs1, a_rs2, a_rd;

  ysyx_22041412_decode_stage #(.XLEN(64), .RVM_EN(1)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc), .opcode(a_opcode), .func3(a_func3), .func7(a_func7), .rs1(a_rs1),
    .rs2(a_rs2), .rd(a_rd), .imme(a_imme), .v1type(a_v1type), .v2type(a_v2type),
    .mul_en(a_mul_en), .rd_wen(a_rd_wen), .illegal(a_illegal)
  );

  // XLEN=32 variant.
  logic        b_in_ready, b_out_valid, b_func7, b_v1type, b_v2type, b_mul_en, b_rd_wen,
               b_illegal;
  logic [31:0] b_out_pc, b_imme;
  logic [6:0]  b_opcode;
  logic [2:0]  b_func3;
  logic [4:0]  b_rs1, b_rs2, b_rd;

  ysyx_22041412_decode_stage #(.XLEN(32), .RVM_EN(1)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .in_pc(in_pc[31:0]), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc), .opcode(b_opcode), .func3(b_func3), .func7(b_func7), .rs1(b_rs1),
    .rs2(b_rs2), .rd(b_rd), .imme(b_imme), .v1type(b_v1type), .v2type(b_v2type),
    .mul_en(b_mul_en), .rd_wen(b_rd_wen), .illegal(b_illegal)
  );

  // RVM_EN=0 variant.
  logic        c_in_ready, c_out_valid, c_func7, c_v1type, c_v2type, c_mul_en, c_rd_wen,
               c_illegal;
  logic [63:0] c_out_pc, c_imme;
  logic [6:0]  c_opcode;
  logic [2:0]  c_func3;
  logic [4:0]  c_rs1, c_rs2, c_rd;

  ysyx_22041412_decode_stage #(.XLEN(64), .RVM_EN(0)) u_dutnm (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_pc(c_out_pc), .opcode(c_opcode), .func3(c_func3), .func7(c_func7), .rs1(c_rs1),
    .rs2(c_rs2), .rd(c_rd), .imme(c_imme), .v1type(c_v1type), .v2type(c_v2type),
    .mul_en(c_mul_en), .rd_wen(c_rd_wen), .illegal(c_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_imme", a_imme, 64'd0);
    chk("rst_rd", {59'd0, a_rd}, 64'd0);
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    rst = 1'b0;

    // addi x1,x0,-1
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h1000;
    #1 chk("addi_in_ready", {63'd0, a_in_ready}, 64'd1);
    tick();
    chk("addi_valid", {63'd0, a_out_valid}, 64'd1);
    chk("addi_rd", {59'd0, a_rd}, 64'd1);
    chk("addi_imme", a_imme, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_v2", {63'd0, a_v2type}, 64'd1);
    chk("addi_v1", {63'd0, a_v1type}, 64'd0);
    chk("addi_rdwen", {63'd0, a_rd_wen}, 64'd1);
    chk("addi_pc", a_out_pc, 64'h1000);
    chk("addi_op", {57'd0, a_opcode}, 64'h13);
    chk("addi_b_imme", {32'd0, b_imme}, 64'hFFFF_FFFF);

    // jal x1,8
    in_instr = 32'h008000EF; in_pc = 64'h8000_0000;
    tick();
    chk("jal_imme", a_imme, 64'd8);
    chk("jal_v1", {63'd0, a_v1type}, 64'd1);
    chk("jal_v2", {63'd0, a_v2type}, 64'd1);
    chk("jal_pc", a_out_pc, 64'h8000_0000);
    chk("jal_rdwen", {63'd0, a_rd_wen}, 64'd1);

    // lui x5,0x80000
    in_instr = 32'h800002B7;
    tick();
    chk("lui64_imme", a_imme, 64'hFFFF_FFFF_8000_0000);
    chk("lui32_imme", {32'd0, b_imme}, 64'h8000_0000);
    chk("lui_rd", {59'd0, a_rd}, 64'd5);
    chk("lui_v1", {63'd0, a_v1type}, 64'd0);

    // mul x3,x1,x2
    in_instr = 32'h022081B3;
    tick();
    chk("mul_m_mulen", {63'd0, a_mul_en}, 64'd1);
    chk("mul_m_illegal", {63'd0, a_illegal}, 64'd0);
    chk("mul_m_rdwen", {63'd0, a_rd_wen}, 64'd1);
    chk("mul_m_imme", a_imme, 64'd0);
    chk("mul_nm_illegal", {63'd0, c_illegal}, 64'd1);
    chk("mul_nm_mulen", {63'd0, c_mul_en}, 64'd0);
    chk("mul_nm_rdwen", {63'd0, c_rd_wen}, 64'd0);
    chk("mul_nm_valid", {63'd0, c_out_valid}, 64'd1);

    // addiw x1,x1,1: legal on RV64, illegal on RV32
    in_instr = 32'h0010809B;
    tick();
    chk("addiw64_illegal", {63'd0, a_illegal}, 64'd0);
    chk("addiw64_imme", a_imme, 64'd1);
    chk("addiw32_illegal", {63'd0, b_illegal}, 64'd1);
    chk("addiw32_imme", {32'd0, b_imme}, 64'd0);
    chk("addiw32_rdwen", {63'd0, b_rd_wen}, 64'd0);

    // beq x0,x0,+16
    in_instr = 32'h00000863;
    tick();
    chk("beq_imme", a_imme, 64'd16);
    chk("beq_rdwen", {63'd0, a_rd_wen}, 64'd0);
    chk("beq_v2", {63'd0, a_v2type}, 64'd0);

    // beq with offset -2
    in_instr = 32'hFE000FE3;
    tick();
    chk("beqn_imme", a_imme, 64'hFFFF_FFFF_FFFF_FFFE);

    // sd x2,8(x1)
    in_instr = 32'h0020B423;
    tick();
    chk("sd_imme", a_imme, 64'd8);
    chk("sd_v2", {63'd0, a_v2type}, 64'd1);
    chk("sd_rdwen", {63'd0, a_rd_wen}, 64'd0);
    chk("sd_rs2", {59'd0, a_rs2}, 64'd2);

    // all-zero word: illegal but still delivered
    in_instr = 32'h0000_0000;
    tick();
    chk("zero_illegal", {63'd0, a_illegal}, 64'd1);
    chk("zero_valid", {63'd0, a_out_valid}, 64'd1);

    // idle cycle: out_ready=1, no transfer -> valid drops
    in_valid = 1'b0;
    tick();
    chk("idle_valid", {63'd0, a_out_valid}, 64'd0);

    // backpressure: hold A while B waits
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h2000;
    tick();
    out_ready = 1'b0; in_instr = 32'h008000EF; in_pc = 64'h3000;
    #1 chk("hold_in_ready0", {63'd0, a_in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", {63'd0, a_out_valid}, 64'd1);
      chk("hold_pc", a_out_pc, 64'h2000);
      chk("hold_imme", a_imme, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("hold_in_ready", {63'd0, a_in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", {63'd0, a_in_ready}, 64'd1);
    tick();
    chk("release_pc", a_out_pc, 64'h3000);
    chk("release_imme", a_imme, 64'd8);

    // flush with a held bundle and a pending instruction
    out_ready = 1'b0; flush = 1'b1; in_instr = 32'h800002B7; in_pc = 64'h4000;
    #1 chk("flush_in_ready", {63'd0, a_in_ready}, 64'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", {63'd0, a_out_valid}, 64'd0);
    chk("flush_pc", a_out_pc, 64'h3000);

    // reset mid-operation
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 64'h5000;
    tick();
    out_ready = 1'b0; rst = 1'b1;
    #1 chk("rst_mid_in_ready", {63'd0, a_in_ready}, 64'd0);
    tick();
    chk("rst_mid_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_mid_pc", a_out_pc, 64'd0);
    rst = 1'b0; out_ready = 1'b1; in_pc = 64'h6000;
    #1 chk("post_rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    tick();
    chk("post_rst_valid", {63'd0, a_out_valid}, 64'd1);
    chk("post_rst_pc", a_out_pc, 64'h6000);
    in_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
